sram_arbiter: RTL and testbench

Shares one 32-bit asynchronous SRAM bank (BaseRAM or ExtRAM pins) between the CPU instruction-fetch port and the data (MEM-stage) port. Each access is sequenced as a multi-cycle SRAM read or write with correct ce/oe/we timing. The block returns a one-cycle ack per completed access, so the CPU can stall until its port is acked. It replaces the per-bank wrappers when program and data must live in the same RAM.

---
 rtl/sram_arbiter_if.sv | 25 ++
 rtl/sram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// CPU-side bundle of the shared SRAM arbiter: instruction fetch port and data port.
interface sram_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ack;

    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_sel;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ack;

    modport master (
        output inst_req, inst_addr, data_req, data_we, data_addr, data_sel, data_wdata,
        input  inst_rdata, inst_ack, data_rdata, data_ack
    );

    modport slave (
        input  inst_req, inst_addr, data_req, data_we, data_addr, data_sel, data_wdata,
        output inst_rdata, inst_ack, data_rdata, data_ack
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous 32-bit SRAM between instruction and data ports.
// Every SRAM pin and CPU response is driven straight from a register.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    sram_arbiter_if.slave       bus,
    output logic                busy_o,
    inout  wire  [31:0]         ram_data_io,
    output logic [19:0]         ram_addr_o,
    output logic [3:0]          ram_be_n_o,
    output logic                ram_ce_n_o,
    output logic                ram_oe_n_o,
    output logic                ram_we_n_o
);

    typedef enum logic [2:0] {
        StIdle, StRd, StWrSetup, StWrPulse, StWrHold, StAck
    } state_e;

    localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rr_data_q, rr_data_d;
    logic        port_data_q, port_data_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [19:0] ram_addr_q, ram_addr_d;
    logic [3:0]  be_n_q, be_n_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        drive_q, drive_d;
    logic        inst_ack_q, inst_ack_d;
    logic        data_ack_q, data_ack_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        busy_q, busy_d;
    logic        pick_data;
    logic        grant_wr;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.inst_addr[31:22], bus.inst_addr[1:0],
                                bus.data_addr[31:22], bus.data_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_data_d    = rr_data_q;
        port_data_d  = port_data_q;
        sel_d        = sel_q;
        wdata_d      = wdata_q;
        ram_addr_d   = ram_addr_q;
        be_n_d       = 4'b1111;
        ce_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        drive_d      = 1'b0;
        inst_ack_d   = 1'b0;
        data_ack_d   = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        pick_data    = 1'b0;
        grant_wr     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.data_req || bus.inst_req) begin
                    // rr_data_q breaks ties only; it flips solely on a genuine conflict
                    pick_data = bus.data_req && (!bus.inst_req || rr_data_q);
                    if (bus.data_req && bus.inst_req) begin
                        rr_data_d = !rr_data_q;
                    end
                    grant_wr    = pick_data && bus.data_we;
                    port_data_d = pick_data;
                    sel_d       = bus.data_sel;
                    wdata_d     = bus.data_wdata;
                    ram_addr_d  = pick_data ? bus.data_addr[21:2] : bus.inst_addr[21:2];
                    ce_n_d      = 1'b0;
                    if (grant_wr) begin
                        state_d = StWrSetup;
                        be_n_d  = ~bus.data_sel;
                        drive_d = 1'b1;
                    end else begin
                        state_d = StRd;
                        oe_n_d  = 1'b0;
                        be_n_d  = 4'b0000;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StRd: begin
                if (cnt_q == 3'd0) begin
                    state_d = StAck;
                    if (port_data_q) begin
                        data_rdata_d = ram_data_io;
                        data_ack_d   = 1'b1;
                    end else begin
                        inst_rdata_d = ram_data_io;
                        inst_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q - 3'd1;
                    ce_n_d = 1'b0;
                    oe_n_d = 1'b0;
                    be_n_d = 4'b0000;
                end
            end
            StWrSetup: begin
                state_d = StWrPulse;
                cnt_d   = WaitInit;
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = ~sel_q;
                drive_d = 1'b1;
            end
            StWrPulse: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~sel_q;
                drive_d = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d  = cnt_q - 3'd1;
                    we_n_d = 1'b0;
                end
            end
            StWrHold: begin
                state_d    = StAck;
                data_ack_d = 1'b1;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            rr_data_q    <= 1'b1;
            port_data_q  <= 1'b0;
            sel_q        <= 4'b0000;
            wdata_q      <= 32'h0;
            ram_addr_q   <= 20'h0;
            be_n_q       <= 4'b1111;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            drive_q      <= 1'b0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_data_q    <= rr_data_d;
            port_data_q  <= port_data_d;
            sel_q        <= sel_d;
            wdata_q      <= wdata_d;
            ram_addr_q   <= ram_addr_d;
            be_n_q       <= be_n_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            drive_q      <= drive_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign ram_data_io    = drive_q ? wdata_q : 32'hz;
    assign ram_addr_o     = ram_addr_q;
    assign ram_be_n_o     = be_n_q;
    assign ram_ce_n_o     = ce_n_q;
    assign ram_oe_n_o     = oe_n_q;
    assign ram_we_n_o     = we_n_q;
    assign busy_o         = busy_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.inst_ack   = inst_ack_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.data_ack   = data_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a word-array memory model and timing rules.
module tb_sram_arbiter;

    localparam int unsigned W  = 1;
    localparam int unsigned W3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if bus ();
    sram_arbiter_if bus3 ();

    wire  [31:0] ram_data;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n, ram_oe_n, ram_we_n, busy;

    wire  [31:0] ram_data3;
    logic [19:0] ram_addr3;
    logic [3:0]  ram_be_n3;
    logic        ram_ce_n3, ram_oe_n3, ram_we_n3, busy3;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy_o(busy), .ram_data_io(ram_data),
        .ram_addr_o(ram_addr), .ram_be_n_o(ram_be_n), .ram_ce_n_o(ram_ce_n),
        .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n)
    );

    sram_arbiter #(.WAIT_CYCLES(W3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .busy_o(busy3), .ram_data_io(ram_data3),
        .ram_addr_o(ram_addr3), .ram_be_n_o(ram_be_n3), .ram_ce_n_o(ram_ce_n3),
        .ram_oe_n_o(ram_oe_n3), .ram_we_n_o(ram_we_n3)
    );

    // Asynchronous SRAM model (64 words, aliased on address bits [5:0])
    logic [31:0] mem [64];
    assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[5:0]] : 32'hz;
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h3C011230 + 32'(i);
        end else if (!ram_ce_n && !ram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!ram_be_n[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_data[8*b +: 8];
            end
        end
    end

    assign ram_data3 = (!ram_ce_n3 && !ram_oe_n3) ? {12'hCAF, ram_addr3} : 32'hz;

    logic [31:0] ref_mem [64];
    logic [31:0] last_inst, last_data;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h3C011230 + 32'(i);
        last_inst = 32'h0;
        last_data = 32'h0;
    endtask

    task automatic idle_bus();
        bus.inst_req  = 1'b0; bus.inst_addr = 32'h0;
        bus.data_req  = 1'b0; bus.data_we   = 1'b0; bus.data_addr = 32'h0;
        bus.data_sel  = 4'h0; bus.data_wdata = 32'h0;
        bus3.inst_req = 1'b0; bus3.inst_addr = 32'h0;
        bus3.data_req = 1'b0; bus3.data_we   = 1'b0; bus3.data_addr = 32'h0;
        bus3.data_sel = 4'h0; bus3.data_wdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_bus();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ref_init();
    endtask

    // One isolated access on the W=1 instance, checked against timing rules and ref_mem
    task automatic do_access(input bit is_data, input bit wr, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata);
        int lat, oe_lo, we_lo, idx;
        bit done;
        logic [31:0] rd;
        logic [19:0] seen_addr;
        logic [3:0]  seen_be;
        idx = int'(addr[7:2]);
        @(negedge clk);
        if (is_data) begin
            bus.data_req = 1'b1; bus.data_we = wr; bus.data_addr = addr;
            bus.data_sel = sel;  bus.data_wdata = wdata;
        end else begin
            bus.inst_req = 1'b1; bus.inst_addr = addr;
        end
        lat = 0; oe_lo = 0; we_lo = 0; done = 1'b0; rd = 32'h0;
        seen_addr = 20'h0; seen_be = 4'hf;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!ram_oe_n) oe_lo++;
            if (!ram_we_n) we_lo++;
            if (!ram_ce_n) begin
                seen_addr = ram_addr;
                seen_be   = ram_be_n;
            end
            check_eq("oe_we_excl", {31'b0, ram_oe_n | ram_we_n}, 32'd1);
            check_eq("stray_ack", {31'b0, is_data ? bus.inst_ack : bus.data_ack}, 32'd0);
            if (is_data ? bus.data_ack : bus.inst_ack) begin
                done = 1'b1;
                rd   = is_data ? bus.data_rdata : bus.inst_rdata;
            end
        end
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        check_eq("ack_seen", {31'b0, done}, 32'd1);
        check_eq("latency", 32'(lat), wr ? 32'(W + 3) : 32'(W + 1));
        check_eq("oe_cycles", 32'(oe_lo), wr ? 32'd0 : 32'(W));
        check_eq("we_cycles", 32'(we_lo), wr ? 32'(W) : 32'd0);
        check_eq("ram_addr", {12'h0, seen_addr}, {12'h0, addr[21:2]});
        check_eq("be_n", {28'h0, seen_be}, wr ? {28'h0, ~sel} : 32'h0);
        if (wr) begin
            for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            check_eq(is_data ? "data_rdata" : "inst_rdata", rd, ref_mem[idx]);
            if (is_data) last_data = ref_mem[idx];
            else         last_inst = ref_mem[idx];
        end
        if (is_data) check_eq("inst_rdata_hold", bus.inst_rdata, last_inst);
        else         check_eq("data_rdata_hold", bus.data_rdata, last_data);
        @(negedge clk);
        check_eq("ack_pulse", {31'b0, is_data ? bus.data_ack : bus.inst_ack}, 32'd0);
        if (wr) check_eq("mem_word", mem[idx], ref_mem[idx]);
    endtask

    // Access on the W=3 instance: returns latency and low-strobe cycle count
    task automatic do_access3(input bit wr, output int lat, output int lo,
                              output logic [31:0] rd);
        bit done;
        @(negedge clk);
        if (wr) begin
            bus3.data_req = 1'b1; bus3.data_we = 1'b1; bus3.data_addr = 32'h14;
            bus3.data_sel = 4'hf; bus3.data_wdata = 32'h55AA55AA;
        end else begin
            bus3.inst_req = 1'b1; bus3.inst_addr = 32'h14;
        end
        lat = 0; lo = 0; done = 1'b0; rd = 32'h0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (wr ? !ram_we_n3 : !ram_oe_n3) lo++;
            if (wr ? bus3.data_ack : bus3.inst_ack) begin
                done = 1'b1;
                rd   = bus3.inst_rdata;
            end
        end
        bus3.inst_req = 1'b0;
        bus3.data_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle_bus();
        ref_init();
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_strobes", {29'b0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
        check_eq("rst_be_n", {28'h0, ram_be_n}, 32'hf);
        check_eq("rst_addr", {12'h0, ram_addr}, 32'h0);
        check_eq("rst_acks", {30'b0, bus.inst_ack, bus.data_ack}, 32'h0);
        check_eq("rst_rdata", bus.inst_rdata | bus.data_rdata, 32'h0);
        do_reset();

        do_access(1'b0, 1'b0, 32'h00000010, 4'h0, 32'h0);
        check_eq("word4_read", last_inst, 32'h3C011234);
        do_access(1'b1, 1'b1, 32'h00000008, 4'b0010, 32'h0000AB00);
        check_eq("byte_write", mem[2], 32'h3C01AB32);
        do_access(1'b1, 1'b1, 32'h0000000C, 4'b0000, 32'hFFFFFFFF);
        check_eq("sel0_write", mem[3], 32'h3C011233);

        repeat (40) begin
            logic is_data, wr;
            is_data = 1'($urandom_range(0, 1));
            wr      = is_data & 1'($urandom_range(0, 1));
            do_access(is_data, wr, $urandom, 4'($urandom), $urandom);
        end

        begin : conflict
            int order[$];
            int cyc, last_ack;
            do_reset();
            @(negedge clk);
            bus.inst_req = 1'b1; bus.inst_addr = 32'h20;
            bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h24;
            cyc = 0; last_ack = 0;
            while (order.size() < 4 && cyc < 60) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                check_eq("dual_ack", {31'b0, bus.data_ack & bus.inst_ack}, 32'd0);
                if (bus.data_ack || bus.inst_ack) begin
                    order.push_back(bus.data_ack ? 1 : 0);
                    check_eq("ack_gap", 32'(cyc - last_ack),
                             order.size() == 1 ? 32'(W + 1) : 32'(W + 2));
                    if (bus.data_ack) check_eq("rr_data_rdata", bus.data_rdata, ref_mem[9]);
                    else              check_eq("rr_inst_rdata", bus.inst_rdata, ref_mem[8]);
                    last_ack = cyc;
                end
            end
            bus.inst_req = 1'b0;
            bus.data_req = 1'b0;
            check_eq("conflict_acks", 32'(order.size()), 32'd4);
            foreach (order[i]) check_eq("grant_order", 32'(order[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        begin : back_to_back
            int acks, idle, cyc, first_ack;
            repeat (2) @(negedge clk);
            bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h18;
            acks = 0; idle = 0; cyc = 0; first_ack = 0;
            while (acks < 2 && cyc < 60) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (acks == 1 && !busy) idle++;
                if (bus.data_ack) begin
                    acks++;
                    if (acks == 1) first_ack = cyc;
                    else check_eq("b2b_gap", 32'(cyc - first_ack), 32'(W + 2));
                end
            end
            bus.data_req = 1'b0;
            check_eq("b2b_acks", 32'(acks), 32'd2);
            check_eq("b2b_idle", 32'(idle), 32'd1);
        end

        begin : reset_mid_write
            int cyc;
            bit saw_ack;
            @(negedge clk);
            @(negedge clk);
            bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 32'h30;
            bus.data_sel = 4'hf; bus.data_wdata = 32'h12345678;
            cyc = 0;
            while (ram_we_n && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check_eq("pulse_reached", {31'b0, ram_we_n}, 32'd0);
            #1 rst = 1'b0;
            #1;
            check_eq("rstw_we_n", {31'b0, ram_we_n}, 32'd1);
            check_eq("rstw_ce_n", {31'b0, ram_ce_n}, 32'd1);
            check_eq("rstw_busy", {31'b0, busy}, 32'd0);
            check_eq("rstw_ack", {31'b0, bus.data_ack}, 32'd0);
            bus.data_req = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            ref_init();
            saw_ack = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (bus.data_ack) saw_ack = 1'b1;
            end
            check_eq("rstw_no_ack", {31'b0, saw_ack}, 32'd0);
            check_eq("rstw_idle", {31'b0, busy}, 32'd0);
        end

        begin : wait3
            int lat, lo;
            logic [31:0] rd;
            do_access3(1'b0, lat, lo, rd);
            check_eq("w3_rd_oe", 32'(lo), 32'd3);
            check_eq("w3_rd_lat", 32'(lat), 32'd4);
            check_eq("w3_rd_data", rd, 32'hCAF00005);
            do_access3(1'b1, lat, lo, rd);
            check_eq("w3_wr_we", 32'(lo), 32'd3);
            check_eq("w3_wr_lat", 32'(lat), 32'd6);
        end

        do_access(1'b0, 1'b0, 32'h00000010, 4'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
